// File: rtl/core_pkg.sv
// Shared core widths, ALU/writeback encodings and the EX/MEM payload record.
package core_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR,  ALU_AND, ALU_EQ,  ALU_NE,  ALU_LT,   ALU_GE,  ALU_LTU, ALU_GEU
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4
    } wb_sel_e;

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic                      mem_write;
        logic                      mem_read;
        logic                      reg_write;
        wb_sel_e                   wb_sel;
    } exmem_t;

    // Jump targets must be halfword aligned.
    function automatic logic [DATA_WIDTH-1:0] clear_lsb(input logic [DATA_WIDTH-1:0] x);
        return {x[DATA_WIDTH-1:1], 1'b0};
    endfunction
endpackage

// File: rtl/id2ex_if.sv
// Decoded instruction bundle travelling from ID to EX.
interface ID2EX_if;
    import core_pkg::*;

    logic [DATA_WIDTH-1:0]     immediate;
    logic [DATA_WIDTH-1:0]     rd_data1;
    logic [DATA_WIDTH-1:0]     rd_data2;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic                      ALUSrcA;
    logic                      ALUSrcB;
    alu_op_e                   ALUOp;
    logic                      Branch;
    logic                      Jump;
    logic                      MemWrite;
    logic                      MemRead;
    logic                      RegWrite;
    wb_sel_e                   WBSel;

    modport MASTER (output immediate, rd_data1, rd_data2, rd_addr, pc, pc_plus4, ALUSrcA,
                    ALUSrcB, ALUOp, Branch, Jump, MemWrite, MemRead, RegWrite, WBSel);
    modport SLAVE  (input  immediate, rd_data1, rd_data2, rd_addr, pc, pc_plus4, ALUSrcA,
                    ALUSrcB, ALUOp, Branch, Jump, MemWrite, MemRead, RegWrite, WBSel);
endinterface

// File: rtl/ex_stage_alu.sv
// Combinational integer ALU; comparison ops yield 0/1 so bit 0 drives branch decisions.
module alu
    import core_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  alu_op_e               op,
    output logic [DATA_WIDTH-1:0] result
);
    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;
    logic       eq;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_EQ:   result = {{(DATA_WIDTH-1){1'b0}}, eq};
            ALU_NE:   result = {{(DATA_WIDTH-1){1'b0}}, !eq};
            ALU_LT:   result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            ALU_GE:   result = {{(DATA_WIDTH-1){1'b0}}, !lt_s};
            ALU_LTU:  result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
            ALU_GEU:  result = {{(DATA_WIDTH-1){1'b0}}, !lt_u};
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch/jump resolution, EX/MEM register,
// registered fetch redirect and wrong-path squash of the bundle following a redirect.
module ex_stage
    import core_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    ID2EX_if.SLAVE                    id_ex,
    input  logic                      id_valid,
    input  logic                      mem_stall,
    output logic                      ex_ready,
    output logic                      exm_valid,
    output logic [DATA_WIDTH-1:0]     exm_alu_result,
    output logic [DATA_WIDTH-1:0]     exm_store_data,
    output logic [REG_ADDR_WIDTH-1:0] exm_rd_addr,
    output logic [DATA_WIDTH-1:0]     exm_pc_plus4,
    output logic                      exm_mem_write,
    output logic                      exm_mem_read,
    output logic                      exm_reg_write,
    output wb_sel_e                   exm_wb_sel,
    output logic                      redirect_o,
    output logic [DATA_WIDTH-1:0]     redirect_pc
);
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] target;
    logic                  taken;

    exmem_t                exm_q, exm_d;
    logic                  redirect_q, redirect_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                  kill_q, kill_d;

    assign op_a = id_ex.ALUSrcA ? id_ex.pc        : id_ex.rd_data1;
    assign op_b = id_ex.ALUSrcB ? id_ex.immediate : id_ex.rd_data2;

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (id_ex.ALUOp),
        .result (alu_res)
    );

    assign taken  = id_ex.Jump || (id_ex.Branch && alu_res[0]);
    assign target = id_ex.Jump ? clear_lsb(alu_res) : id_ex.pc + id_ex.immediate;

    always_comb begin
        exm_d         = exm_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        kill_d        = kill_q;
        if (!mem_stall) begin
            exm_d = '0;
            if (id_valid) begin
                if (kill_q) begin
                    // Wrong-path bundle behind a redirect: drop it and re-arm.
                    kill_d = 1'b0;
                end else begin
                    exm_d.valid      = 1'b1;
                    exm_d.alu_result = alu_res;
                    exm_d.store_data = id_ex.rd_data2;
                    exm_d.rd_addr    = id_ex.rd_addr;
                    exm_d.pc_plus4   = id_ex.pc_plus4;
                    exm_d.mem_write  = id_ex.MemWrite;
                    exm_d.mem_read   = id_ex.MemRead;
                    exm_d.reg_write  = id_ex.RegWrite;
                    exm_d.wb_sel     = id_ex.WBSel;
                    if (taken) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = target;
                        kill_d        = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exm_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            exm_q         <= exm_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            kill_q        <= kill_d;
        end
    end

    assign ex_ready       = !mem_stall;
    assign exm_valid      = exm_q.valid;
    assign exm_alu_result = exm_q.alu_result;
    assign exm_store_data = exm_q.store_data;
    assign exm_rd_addr    = exm_q.rd_addr;
    assign exm_pc_plus4   = exm_q.pc_plus4;
    assign exm_mem_write  = exm_q.valid && exm_q.mem_write;
    assign exm_mem_read   = exm_q.valid && exm_q.mem_read;
    assign exm_reg_write  = exm_q.valid && exm_q.reg_write;
    assign exm_wb_sel     = exm_q.wb_sel;
    assign redirect_o     = redirect_q;
    assign redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an instruction-level model.
module tb_ex_stage;
    import core_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      id_valid;
    logic                      mem_stall;
    logic                      ex_ready;
    logic                      exm_valid;
    logic [DATA_WIDTH-1:0]     exm_alu_result;
    logic [DATA_WIDTH-1:0]     exm_store_data;
    logic [REG_ADDR_WIDTH-1:0] exm_rd_addr;
    logic [DATA_WIDTH-1:0]     exm_pc_plus4;
    logic                      exm_mem_write;
    logic                      exm_mem_read;
    logic                      exm_reg_write;
    wb_sel_e                   exm_wb_sel;
    logic                      redirect_o;
    logic [DATA_WIDTH-1:0]     redirect_pc;

    ID2EX_if id_ex_if ();

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .id_ex          (id_ex_if),
        .id_valid       (id_valid),
        .mem_stall      (mem_stall),
        .ex_ready       (ex_ready),
        .exm_valid      (exm_valid),
        .exm_alu_result (exm_alu_result),
        .exm_store_data (exm_store_data),
        .exm_rd_addr    (exm_rd_addr),
        .exm_pc_plus4   (exm_pc_plus4),
        .exm_mem_write  (exm_mem_write),
        .exm_mem_read   (exm_mem_read),
        .exm_reg_write  (exm_reg_write),
        .exm_wb_sel     (exm_wb_sel),
        .redirect_o     (redirect_o),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural expectation of the stage as seen by MEM and fetch.
    logic        m_valid, m_mw, m_mr, m_rw, m_redir, m_kill;
    logic [31:0] m_alu, m_store, m_pc4, m_rpc;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        int unsigned sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return 32'(sa >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_EQ:   return (a == b) ? 32'd1 : 32'd0;
            ALU_NE:   return (a != b) ? 32'd1 : 32'd0;
            ALU_LT:   return (sa < sb) ? 32'd1 : 32'd0;
            ALU_GE:   return (sa >= sb) ? 32'd1 : 32'd0;
            ALU_LTU:  return (a < b) ? 32'd1 : 32'd0;
            default:  return (a >= b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_alu = 0; m_store = 0; m_rd = 0; m_pc4 = 0;
        m_mw = 0; m_mr = 0; m_rw = 0; m_wb = 0;
    endtask

    // Effect of one clock edge given the inputs presented before it.
    task automatic model_step();
        logic [31:0] a, b, r;
        if (rst) begin
            model_bubble();
            m_redir = 0; m_rpc = 0; m_kill = 0;
        end else if (mem_stall) begin
            m_redir = 0;
        end else if (id_valid && !m_kill) begin
            a = id_ex_if.ALUSrcA ? id_ex_if.pc : id_ex_if.rd_data1;
            b = id_ex_if.ALUSrcB ? id_ex_if.immediate : id_ex_if.rd_data2;
            r = ref_alu(id_ex_if.ALUOp, a, b);
            m_valid = 1; m_alu = r; m_store = id_ex_if.rd_data2; m_rd = id_ex_if.rd_addr;
            m_pc4 = id_ex_if.pc_plus4; m_mw = id_ex_if.MemWrite; m_mr = id_ex_if.MemRead;
            m_rw = id_ex_if.RegWrite; m_wb = id_ex_if.WBSel;
            m_redir = 0;
            if (id_ex_if.Jump) begin
                m_redir = 1; m_rpc = r & 32'hFFFF_FFFE; m_kill = 1;
            end else if (id_ex_if.Branch && (r == 1)) begin
                m_redir = 1; m_rpc = id_ex_if.pc + id_ex_if.immediate; m_kill = 1;
            end
        end else begin
            model_bubble();
            if (id_valid) m_kill = 0;
            m_redir = 0;
        end
    endtask

    task automatic compare_all();
        chk("exm_valid", {31'b0, exm_valid}, {31'b0, m_valid});
        chk("exm_alu_result", exm_alu_result, m_alu);
        chk("exm_store_data", exm_store_data, m_store);
        chk("exm_rd_addr", {27'b0, exm_rd_addr}, {27'b0, m_rd});
        chk("exm_pc_plus4", exm_pc_plus4, m_pc4);
        chk("exm_mem_write", {31'b0, exm_mem_write}, {31'b0, m_mw});
        chk("exm_mem_read", {31'b0, exm_mem_read}, {31'b0, m_mr});
        chk("exm_reg_write", {31'b0, exm_reg_write}, {31'b0, m_rw});
        chk("exm_wb_sel", {30'b0, exm_wb_sel}, {30'b0, m_wb});
        chk("redirect_o", {31'b0, redirect_o}, {31'b0, m_redir});
        chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic cycle();
        #1;
        chk("ex_ready", {31'b0, ex_ready}, {31'b0, !mem_stall});
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_bundle();
        id_ex_if.immediate = 0; id_ex_if.rd_data1 = 0; id_ex_if.rd_data2 = 0;
        id_ex_if.rd_addr = 0; id_ex_if.pc = 0; id_ex_if.pc_plus4 = 0;
        id_ex_if.ALUSrcA = 0; id_ex_if.ALUSrcB = 0; id_ex_if.ALUOp = ALU_ADD;
        id_ex_if.Branch = 0; id_ex_if.Jump = 0; id_ex_if.MemWrite = 0;
        id_ex_if.MemRead = 0; id_ex_if.RegWrite = 0; id_ex_if.WBSel = WB_ALU;
    endtask

    task automatic add_imm(input logic [31:0] rs1, input logic [31:0] imm, input logic [4:0] rd);
        clear_bundle();
        id_valid = 1;
        id_ex_if.rd_data1 = rs1; id_ex_if.immediate = imm; id_ex_if.ALUSrcB = 1;
        id_ex_if.rd_addr = rd; id_ex_if.RegWrite = 1;
    endtask

    task automatic branch(input alu_op_e op, input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm);
        clear_bundle();
        id_valid = 1;
        id_ex_if.ALUOp = op; id_ex_if.pc = pc; id_ex_if.pc_plus4 = pc + 4;
        id_ex_if.rd_data1 = rs1; id_ex_if.rd_data2 = rs2; id_ex_if.immediate = imm;
        id_ex_if.Branch = 1;
    endtask

    initial begin
        rst = 1; mem_stall = 0; id_valid = 0;
        clear_bundle();
        model_bubble(); m_redir = 0; m_rpc = 0; m_kill = 0;
        cycle(); cycle();
        chk("reset exm_valid", {31'b0, exm_valid}, 32'd0);
        chk("reset redirect_o", {31'b0, redirect_o}, 32'd0);
        chk("reset redirect_pc", redirect_pc, 32'd0);
        rst = 0;

        add_imm(32'd5, 32'd7, 5'd3);
        cycle();
        chk("add valid", {31'b0, exm_valid}, 32'd1);
        chk("add result", exm_alu_result, 32'd12);
        chk("add rd", {27'b0, exm_rd_addr}, 32'd3);
        chk("add no redirect", {31'b0, redirect_o}, 32'd0);

        branch(ALU_EQ, 32'h100, 32'd9, 32'd9, 32'h20);
        cycle();
        chk("beq redirect", {31'b0, redirect_o}, 32'd1);
        chk("beq target", redirect_pc, 32'h120);
        add_imm(32'd1, 32'd1, 5'd4);
        cycle();
        chk("squash valid", {31'b0, exm_valid}, 32'd0);
        chk("redirect one cycle", {31'b0, redirect_o}, 32'd0);
        chk("squash reg_write", {31'b0, exm_reg_write}, 32'd0);
        cycle();
        chk("post squash valid", {31'b0, exm_valid}, 32'd1);
        chk("post squash result", exm_alu_result, 32'd2);

        branch(ALU_NE, 32'h180, 32'd4, 32'd4, 32'h40);
        cycle();
        chk("bne not taken", {31'b0, redirect_o}, 32'd0);
        chk("bne valid", {31'b0, exm_valid}, 32'd1);

        add_imm(32'h203, 32'd0, 5'd1);
        id_ex_if.Jump = 1; id_ex_if.WBSel = WB_PC4;
        id_ex_if.pc = 32'h300; id_ex_if.pc_plus4 = 32'h304;
        cycle();
        chk("jalr redirect", {31'b0, redirect_o}, 32'd1);
        chk("jalr target", redirect_pc, 32'h202);
        chk("jalr link", exm_pc_plus4, 32'h304);
        chk("jalr reg_write", {31'b0, exm_reg_write}, 32'd1);
        id_valid = 0;
        cycle();
        add_imm(32'd8, 32'd8, 5'd2);
        cycle();
        chk("kill across idle", {31'b0, exm_valid}, 32'd0);

        add_imm(32'h1000, 32'd8, 5'd5);
        id_ex_if.MemRead = 1; id_ex_if.WBSel = WB_MEM;
        cycle();
        chk("load addr", exm_alu_result, 32'h1008);
        add_imm(32'h10, 32'h20, 5'd6);
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall ex_ready", {31'b0, ex_ready}, 32'd0);
            chk("stall hold addr", exm_alu_result, 32'h1008);
            chk("stall hold mem_read", {31'b0, exm_mem_read}, 32'd1);
            chk("stall hold rd", {27'b0, exm_rd_addr}, 32'd5);
        end
        mem_stall = 0;
        cycle();
        chk("release result", exm_alu_result, 32'h30);
        chk("release rd", {27'b0, exm_rd_addr}, 32'd6);

        branch(ALU_EQ, 32'h500, 32'd1, 32'd1, 32'h40);
        cycle();
        chk("pre-reset redirect", redirect_pc, 32'h540);
        add_imm(32'd2, 32'd3, 5'd7);
        mem_stall = 1;
        cycle();
        rst = 1;
        cycle();
        chk("rst in stall valid", {31'b0, exm_valid}, 32'd0);
        chk("rst in stall pc", redirect_pc, 32'd0);
        chk("rst in stall rd", {27'b0, exm_rd_addr}, 32'd0);
        rst = 0; mem_stall = 0;
        cycle();
        chk("post reset accept", {31'b0, exm_valid}, 32'd1);
        chk("post reset result", exm_alu_result, 32'd5);

        for (int n = 0; n < 3000; n++) begin
            clear_bundle();
            rst       = ($urandom_range(0, 99) == 0);
            mem_stall = ($urandom_range(0, 4) == 0);
            id_valid  = ($urandom_range(0, 3) != 0);
            id_ex_if.rd_data1  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 40) : $urandom;
            id_ex_if.rd_data2  = ($urandom_range(0, 2) == 0) ? id_ex_if.rd_data1 : $urandom;
            id_ex_if.immediate = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 64) : $urandom;
            id_ex_if.pc        = {$urandom_range(0, 16'hFFFF), 2'b00};
            id_ex_if.pc_plus4  = id_ex_if.pc + 4;
            id_ex_if.rd_addr   = 5'($urandom_range(0, 31));
            id_ex_if.ALUSrcA   = $urandom_range(0, 1) == 1;
            id_ex_if.ALUSrcB   = $urandom_range(0, 1) == 1;
            id_ex_if.ALUOp     = alu_op_e'($urandom_range(0, 15));
            id_ex_if.MemWrite  = $urandom_range(0, 1) == 1;
            id_ex_if.MemRead   = $urandom_range(0, 1) == 1;
            id_ex_if.RegWrite  = $urandom_range(0, 1) == 1;
            id_ex_if.WBSel     = wb_sel_e'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0, 1: begin
                    id_ex_if.Branch  = 1;
                    id_ex_if.ALUSrcA = 0;
                    id_ex_if.ALUSrcB = 0;
                    id_ex_if.ALUOp   = alu_op_e'($urandom_range(10, 15));
                end
                2: id_ex_if.Jump = 1;
                default: ;
            endcase
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
